button_event_decoder: RTL and testbench

Consumes the debounced per-button levels produced by the input debouncer and turns them into discrete, queued button events: PRESS, RELEASE, LONG and REPEAT. Each event is tagged with its channel index. Events are delivered over a valid/ready stream to the control logic that owns UI state. It sits directly downstream of the debouncer on the same port vector.

---
 rtl/btn_evt_pkg.sv | 26 ++
 rtl/btn_evt_fifo.sv | 55 +++++
 rtl/button_event_decoder.sv | 192 +++++++++++++++++++
 tb/tb_button_event_decoder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_evt_pkg.sv
// Shared definitions for the button event decoder: event codes, per-channel
// FSM state encoding and width helpers for the queued event record.
package btn_evt_pkg;

    localparam logic [1:0] EVT_PRESS   = 2'd0;
    localparam logic [1:0] EVT_RELEASE = 2'd1;
    localparam logic [1:0] EVT_LONG    = 2'd2;
    localparam logic [1:0] EVT_REPEAT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } btn_state_t;

    // Channel index width, never narrower than one bit
    function automatic int chan_width(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

    // Queued record is {channel, code}
    function automatic int evt_rec_width(input int chan_w);
        return chan_w + 2;
    endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// Small synchronous FIFO holding {channel, code} event records. The head is
// read straight out of registered storage so it stays put under backpressure.
// The caller never pushes when full unless it pops in the same cycle, and
// never pops when empty.
module btn_evt_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/button_event_decoder.sv
// Turns debounced button levels into queued PRESS / RELEASE / LONG / REPEAT
// events tagged with their channel, delivered over a valid/ready stream.
// Optional feature macro: BTN_EVT_REPEAT_EN enables REPEAT generation in HELD.
module button_event_decoder
    import btn_evt_pkg::*;
#(
    parameter int PORT_WIDTH    = 4,
    parameter int LONG_CLOCKS   = 1000000,
    parameter int REPEAT_CLOCKS = 250000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [PORT_WIDTH-1:0]               btn_in,
    output logic                                evt_valid,
    input  logic                                evt_ready,
    output logic [chan_width(PORT_WIDTH)-1:0]   evt_chan,
    output logic [1:0]                          evt_code,
    output logic                                overflow,
    input  logic                                overflow_clr
);

    localparam int CHAN_W = chan_width(PORT_WIDTH);
    localparam int REC_W  = evt_rec_width(CHAN_W);
`ifdef BTN_EVT_REPEAT_EN
    localparam int MAX_CLOCKS = (LONG_CLOCKS > REPEAT_CLOCKS) ? LONG_CLOCKS : REPEAT_CLOCKS;
`else
    localparam int MAX_CLOCKS = LONG_CLOCKS;
`endif
    localparam int CNT_W = $clog2(MAX_CLOCKS);
    localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CLOCKS - 1);
`ifdef BTN_EVT_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CLOCKS - 1);
`endif

    logic [PORT_WIDTH-1:0] prev;
    logic                  primed;
    logic [PORT_WIDTH-1:0] pend_valid;
    logic [1:0]            pend_code [PORT_WIDTH];
    logic [PORT_WIDTH-1:0] grant;
    logic [PORT_WIDTH-1:0] drop;
    logic                  found;
    logic [CHAN_W-1:0]     grant_chan;
    logic [1:0]            grant_code;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic                  can_accept;
    logic [REC_W-1:0]      head;

    // Previous levels; the first clock after reset only captures them so a
    // button already held through reset does not look like a fresh press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev   <= '0;
            primed <= 1'b0;
        end else begin
            prev   <= btn_in;
            primed <= 1'b1;
        end
    end

    for (genvar g = 0; g < PORT_WIDTH; g++) begin : g_chan
        btn_state_t       state;
        logic [CNT_W-1:0] cnt;
        logic             rise;
        logic             fall;
        logic             held_high;
        logic             ch_emit;
        logic [1:0]       ch_code;
        logic             ch_pend;
        logic [1:0]       ch_pend_code;

        assign rise      = primed & btn_in[g] & ~prev[g];
        assign fall      = primed & ~btn_in[g] & prev[g];
        assign held_high = btn_in[g] & prev[g];

        // Event decode; a fall always beats a terminal count in the same cycle
        always_comb begin
            ch_emit = 1'b0;
            ch_code = EVT_PRESS;
            if (rise) begin
                ch_emit = 1'b1;
                ch_code = EVT_PRESS;
            end else if (fall && state != ST_IDLE) begin
                ch_emit = 1'b1;
                ch_code = EVT_RELEASE;
            end else if (held_high && state == ST_PRESSED && cnt == LONG_TC) begin
                ch_emit = 1'b1;
                ch_code = EVT_LONG;
`ifdef BTN_EVT_REPEAT_EN
            end else if (held_high && state == ST_HELD && cnt == REPEAT_TC) begin
                ch_emit = 1'b1;
                ch_code = EVT_REPEAT;
`endif
            end
        end

        // Channel FSM, hold counter and one-entry pending register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state        <= ST_IDLE;
                cnt          <= '0;
                ch_pend      <= 1'b0;
                ch_pend_code <= EVT_PRESS;
            end else begin
                if (rise) begin
                    state <= ST_PRESSED;
                    cnt   <= '0;
                end else if (fall && state != ST_IDLE) begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end else if (held_high && state == ST_PRESSED) begin
                    if (cnt == LONG_TC) begin
                        state <= ST_HELD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`ifdef BTN_EVT_REPEAT_EN
                end else if (held_high && state == ST_HELD) begin
                    if (cnt == REPEAT_TC) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end

                if (ch_emit && (!ch_pend || grant[g])) begin
                    ch_pend      <= 1'b1;
                    ch_pend_code <= ch_code;
                end else if (grant[g]) begin
                    ch_pend <= 1'b0;
                end
            end
        end

        assign pend_valid[g] = ch_pend;
        assign pend_code[g]  = ch_pend_code;
        assign drop[g]       = ch_emit & ch_pend & ~grant[g];
    end

    assign pop        = evt_valid & evt_ready;
    assign can_accept = ~fifo_full | pop;

    // Fixed-priority arbiter: lowest pending channel wins one FIFO slot
    always_comb begin
        grant      = '0;
        found      = 1'b0;
        grant_chan = '0;
        grant_code = EVT_PRESS;
        for (int i = 0; i < PORT_WIDTH; i++) begin
            if (can_accept && pend_valid[i] && !found) begin
                found      = 1'b1;
                grant[i]   = 1'b1;
                grant_chan = CHAN_W'(i);
                grant_code = pend_code[i];
            end
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (|drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    btn_evt_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (found),
        .push_data ({grant_chan, grant_code}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign evt_valid = ~fifo_empty;
    assign evt_chan  = head[REC_W-1:2];
    assign evt_code  = head[1:0];

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder with short hold thresholds.
// Follows BTN_EVT_REPEAT_EN for the expected long-hold sequence.
module tb_button_event_decoder;

    localparam logic [1:0] P  = 2'd0;
    localparam logic [1:0] R  = 2'd1;
    localparam logic [1:0] L  = 2'd2;
    localparam logic [1:0] RP = 2'd3;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn_in;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_chan;
    logic [1:0] evt_code;
    logic       overflow;
    logic       overflow_clr;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] btn;
        logic       ready;
        logic       exp_valid;
        logic [1:0] exp_chan;
        logic [1:0] exp_code;
        logic       exp_ovf;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] captured[$];
    logic [3:0] expq[$];

    button_event_decoder #(
        .PORT_WIDTH    (4),
        .LONG_CLOCKS   (8),
        .REPEAT_CLOCKS (4),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_in       (btn_in),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_chan     (evt_chan),
        .evt_code     (evt_code),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted event as {chan, code}
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            captured.push_back({evt_chan, evt_code});
        end
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [3:0] btn, input logic ready, input logic clr);
        btn_in       = btn;
        evt_ready    = ready;
        overflow_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic checkEvents(input string name);
        int n;
        checkOutput({name, " count"}, 32'(captured.size()), 32'(expq.size()));
        n = (captured.size() < expq.size()) ? captured.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s evt%0d", name, i), 32'(captured[i]), 32'(expq[i]));
        end
    endtask

    task automatic addVec(input logic [3:0] btn, input logic ready, input logic ev,
                          input logic [1:0] ch, input logic [1:0] code, input logic ovf);
        vec_t v;
        v.btn       = btn;
        v.ready     = ready;
        v.exp_valid = ev;
        v.exp_chan  = ch;
        v.exp_code  = code;
        v.exp_ovf   = ovf;
        vecs.push_back(v);
    endtask

    initial begin
        // Short press on chan 2: valid two edges after the rise is sampled
        addVec(4'b0000, 1, 0, 0, P, 0);
        addVec(4'b0100, 1, 0, 0, P, 0);
        addVec(4'b0100, 1, 1, 2, P, 0);
        addVec(4'b0100, 1, 0, 0, P, 0);
        addVec(4'b0000, 1, 0, 0, P, 0);
        addVec(4'b0000, 1, 1, 2, R, 0);
        addVec(4'b0000, 1, 0, 0, P, 0);
        // All four rise together: PRESS drains 0,1,2,3 on consecutive cycles
        addVec(4'b1111, 1, 0, 0, P, 0);
        addVec(4'b1111, 1, 1, 0, P, 0);
        addVec(4'b1111, 1, 1, 1, P, 0);
        addVec(4'b1111, 1, 1, 2, P, 0);
        addVec(4'b1111, 1, 1, 3, P, 0);
        addVec(4'b1111, 1, 0, 0, P, 0);
        addVec(4'b0000, 1, 0, 0, P, 0);
        addVec(4'b0000, 1, 1, 0, R, 0);
        addVec(4'b0000, 1, 1, 1, R, 0);
        addVec(4'b0000, 1, 1, 2, R, 0);
        addVec(4'b0000, 1, 1, 3, R, 0);
        addVec(4'b0000, 1, 0, 0, P, 0);

        rst_n        = 1'b0;
        btn_in       = 4'b0000;
        evt_ready    = 1'b1;
        overflow_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset valid", 32'(evt_valid), 32'd0);
        checkOutput("reset chan", 32'(evt_chan), 32'd0);
        checkOutput("reset code", 32'(evt_code), 32'd0);
        checkOutput("reset overflow", 32'(overflow), 32'd0);
        #3 rst_n = 1'b1;
        applyStimulus(4'b0000, 1, 0);
        applyStimulus(4'b0000, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].btn, vecs[i].ready, 1'b0);
            checkOutput($sformatf("vec%0d valid", i), 32'(evt_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("vec%0d chan", i), 32'(evt_chan), 32'(vecs[i].exp_chan));
                checkOutput($sformatf("vec%0d code", i), 32'(evt_code), 32'(vecs[i].exp_code));
            end
            checkOutput($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
        end

        // Long hold on chan 0: LONG after 8 more high cycles, REPEAT every 4
        captured.delete();
        expq.delete();
        repeat (21) applyStimulus(4'b0001, 1, 0);
        repeat (5) applyStimulus(4'b0000, 1, 0);
        expq.push_back({2'd0, P});
        expq.push_back({2'd0, L});
`ifdef BTN_EVT_REPEAT_EN
        expq.push_back({2'd0, RP});
        expq.push_back({2'd0, RP});
        expq.push_back({2'd0, RP});
`endif
        expq.push_back({2'd0, R});
        checkEvents("long hold");

        // Fall exactly on the LONG cycle suppresses LONG
        captured.delete();
        expq.delete();
        repeat (8) applyStimulus(4'b0010, 1, 0);
        repeat (5) applyStimulus(4'b0000, 1, 0);
        expq.push_back({2'd1, P});
        expq.push_back({2'd1, R});
        checkEvents("fall on long");

        // One more high cycle lets LONG fire
        captured.delete();
        expq.delete();
        repeat (9) applyStimulus(4'b0010, 1, 0);
        repeat (5) applyStimulus(4'b0000, 1, 0);
        expq.push_back({2'd1, P});
        expq.push_back({2'd1, L});
        expq.push_back({2'd1, R});
        checkEvents("long then fall");

        // Backpressure: 4 queued, 1 pending, 6th dropped with a clear in the same cycle
        captured.delete();
        expq.delete();
        for (int k = 0; k < 6; k++) begin
            applyStimulus((k % 2 == 0) ? 4'b1000 : 4'b0000, 0, (k == 5));
            if (k == 5) begin
                checkOutput("overflow set wins", 32'(overflow), 32'd1);
            end
            applyStimulus((k % 2 == 0) ? 4'b1000 : 4'b0000, 0, 0);
            if (k == 4) begin
                checkOutput("overflow before drop", 32'(overflow), 32'd0);
            end
        end
        checkOutput("stalled valid", 32'(evt_valid), 32'd1);
        checkOutput("stalled chan", 32'(evt_chan), 32'd3);
        checkOutput("stalled code", 32'(evt_code), 32'(P));
        applyStimulus(4'b0000, 1, 1);
        repeat (8) applyStimulus(4'b0000, 1, 0);
        checkOutput("overflow cleared", 32'(overflow), 32'd0);
        expq.push_back({2'd3, P});
        expq.push_back({2'd3, R});
        expq.push_back({2'd3, P});
        expq.push_back({2'd3, R});
        expq.push_back({2'd3, P});
        checkEvents("drain order");

        // Reset while HELD with PRESS and LONG queued
        captured.delete();
        expq.delete();
        repeat (11) applyStimulus(4'b0001, 0, 0);
        checkOutput("pre-reset valid", 32'(evt_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid reset valid", 32'(evt_valid), 32'd0);
        checkOutput("mid reset overflow", 32'(overflow), 32'd0);
        checkOutput("mid reset chan", 32'(evt_chan), 32'd0);
        checkOutput("mid reset code", 32'(evt_code), 32'd0);
        #2 rst_n = 1'b1;
        repeat (12) applyStimulus(4'b0001, 1, 0);
        checkEvents("held through reset");
        repeat (2) applyStimulus(4'b0000, 1, 0);
        repeat (2) applyStimulus(4'b0001, 1, 0);
        repeat (4) applyStimulus(4'b0000, 1, 0);
        expq.push_back({2'd0, P});
        expq.push_back({2'd0, R});
        checkEvents("new rise after reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
